div_req_ctrl: RTL and testbench

- Execute-stage initiator for the iterative 32-bit divider (DIV/DIVU/REM/REMU).
- Latches operands and op, and holds the divider start line for the whole operation.
- Stalls the pipeline until the divider reports ready, selects the quotient or remainder, and issues a one-cycle register writeback.
- Absorbs jump/interrupt flushes mid-operation without writing back, including any spurious ready pulse from the divider.

---
 rtl/div_req_ctrl_pkg.sv | 34 +++
 rtl/div_req_ctrl.sv | 173 +++++++++++++++++
 tb/tb_div_req_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_req_ctrl_pkg
// Shared definitions for the execute-stage divide request controller:
// bus widths, the funct3 encodings of the divide instructions, the
// controller state encoding and the RISC-V divide-by-zero quotient.
// ---------------------------------------------------------------------------
package div_req_ctrl_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;
    localparam int RegAddrBus   = 5;

    // funct3 encodings of the M-extension divide group
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    // Quotient of any division by zero
    localparam logic [RegBus-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WB    = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    // REM/REMU are the only encodings with funct3[1] set
    function automatic logic is_rem_op(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_req_ctrl.sv
// ---------------------------------------------------------------------------
// div_req_ctrl
// Initiator for the iterative 32-bit divider. Latches the operands, op and
// destination of a DIV/DIVU/REM/REMU instruction, holds the divider start
// line for the whole operation, stalls the pipeline until the divider is
// ready, then issues a one-cycle writeback of the quotient or remainder.
// A flush mid-operation drops start and waits for the divider to go idle,
// swallowing any ready pulse, without writing back.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_i, op_i              divide instruction valid in ex, funct3
//   reg1_rdata_i/reg2_rdata_i dividend / divisor
//   reg_waddr_i              destination rd
//   flush_i                  jump/interrupt flush
//   div_*_o                  request to the divider (start held high)
//   div_result_i             {remainder, quotient} from the divider
//   div_ready_i, div_busy_i  divider status
//   div_reg_waddr_i          rd tag echoed by the divider
//   hold_flag_o              pipeline stall request
//   reg_we_o/_waddr_o/_wdata_o writeback port
//
// Build option:
//   DIV_ZERO_BYPASS_EN  when defined, a zero divisor is resolved at accept
//                       (quotient all ones, remainder = dividend) and the
//                       divider is never started.
// ---------------------------------------------------------------------------
module div_req_ctrl
    import div_req_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    input  logic [2:0]              op_i,
    input  logic [RegBus-1:0]       reg1_rdata_i,
    input  logic [RegBus-1:0]       reg2_rdata_i,
    input  logic [RegAddrBus-1:0]   reg_waddr_i,
    input  logic                    flush_i,
    output logic [RegBus-1:0]       div_dividend_o,
    output logic [RegBus-1:0]       div_divisor_o,
    output logic                    div_start_o,
    output logic [2:0]              div_op_o,
    output logic [RegAddrBus-1:0]   div_reg_waddr_o,
    input  logic [DoubleRegBus-1:0] div_result_i,
    input  logic                    div_ready_i,
    input  logic                    div_busy_i,
    input  logic [RegAddrBus-1:0]   div_reg_waddr_i,
    output logic                    hold_flag_o,
    output logic                    reg_we_o,
    output logic [RegAddrBus-1:0]   reg_waddr_o,
    output logic [RegBus-1:0]       reg_wdata_o
);

    state_e                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [RegBus-1:0]       dividend_q, dividend_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic [RegAddrBus-1:0]   rd_q, rd_d;
    logic                    reg_we_q, reg_we_d;
    logic [RegAddrBus-1:0]   reg_waddr_q, reg_waddr_d;
    logic [RegBus-1:0]       reg_wdata_q, reg_wdata_d;

    logic accept;

    assign accept = (state_q == ST_IDLE) && req_i && !flush_i;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rd_d        = rd_q;
        reg_we_d    = 1'b0;          // writeback strobe lasts a single cycle
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d       = op_i;
                    dividend_d = reg1_rdata_i;
                    divisor_d  = reg2_rdata_i;
                    rd_d       = reg_waddr_i;
`ifdef DIV_ZERO_BYPASS_EN
                    if (reg2_rdata_i == '0) begin
                        state_d     = ST_WB;
                        reg_we_d    = 1'b1;
                        reg_waddr_d = reg_waddr_i;
                        reg_wdata_d = is_rem_op(op_i) ? reg1_rdata_i : DIV_ZERO_QUOTIENT;
                    end else begin
                        state_d = ST_WAIT;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_WAIT: begin
                // Flush has priority over a ready arriving in the same cycle
                if (flush_i) begin
                    state_d = ST_ABORT;
                end else if (div_ready_i) begin
                    state_d     = ST_WB;
                    reg_we_d    = 1'b1;
                    reg_waddr_d = rd_q;
                    reg_wdata_d = is_rem_op(op_q) ? div_result_i[DoubleRegBus-1:RegBus]
                                                  : div_result_i[RegBus-1:0];
                end
            end
            ST_WB: begin
                // req_i here still belongs to the retiring instruction
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                // Dropping start can make the divider emit one stale ready;
                // wait until it is fully quiet before taking new work.
                if (!div_busy_i && !div_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rd_q        <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rd_q        <= rd_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // Start is combinational so it falls in the very cycle ready is seen,
    // otherwise the divider would treat the held line as a new request.
    assign div_start_o     = (state_q == ST_WAIT) && !div_ready_i && !flush_i;
    assign div_dividend_o  = dividend_q;
    assign div_divisor_o   = divisor_q;
    assign div_op_o        = op_q;
    assign div_reg_waddr_o = rd_q;

    assign hold_flag_o = accept || (state_q == ST_WAIT) || (state_q == ST_ABORT);

    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;

`ifndef SYNTHESIS
    // The divider echoes rd; a mismatch means request/response got out of step
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_WAIT && div_ready_i && !flush_i) begin
            assert (div_reg_waddr_i == rd_q)
                else $error("div_req_ctrl: divider tag %0d differs from rd %0d", div_reg_waddr_i, rd_q);
        end
    end
`endif

endmodule

// File: tb/tb_div_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_req_ctrl
// Directed bench for div_req_ctrl with a behavioural model of the iterative
// divider: ready arrives 35 cycles after start for a nonzero divisor, one
// cycle for a zero divisor, and a start drop mid-operation produces one
// stale ready pulse with garbage data.
// ---------------------------------------------------------------------------
module tb_div_req_ctrl;
    import div_req_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] reg1_rdata_i, reg2_rdata_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic [31:0] div_dividend_o, div_divisor_o;
    logic        div_start_o;
    logic [2:0]  div_op_o;
    logic [4:0]  div_reg_waddr_o;
    logic [63:0] div_result_i;
    logic        div_ready_i, div_busy_i;
    logic [4:0]  div_reg_waddr_i;
    logic        hold_flag_o, reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_req_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .op_i           (op_i),
        .reg1_rdata_i   (reg1_rdata_i),
        .reg2_rdata_i   (reg2_rdata_i),
        .reg_waddr_i    (reg_waddr_i),
        .flush_i        (flush_i),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_start_o    (div_start_o),
        .div_op_o       (div_op_o),
        .div_reg_waddr_o(div_reg_waddr_o),
        .div_result_i   (div_result_i),
        .div_ready_i    (div_ready_i),
        .div_busy_i     (div_busy_i),
        .div_reg_waddr_i(div_reg_waddr_i),
        .hold_flag_o    (hold_flag_o),
        .reg_we_o       (reg_we_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_o    (reg_wdata_o)
    );

    // ---------------- divider model ----------------
    function automatic logic [63:0] rv_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    logic [63:0] m_calc;
    int          m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            div_busy_i      <= 1'b0;
            div_ready_i     <= 1'b0;
            div_result_i    <= 64'd0;
            div_reg_waddr_i <= 5'd0;
            m_calc          <= 64'd0;
            m_cnt           <= 0;
        end else begin
            div_ready_i <= 1'b0;
            if (!div_busy_i) begin
                if (div_start_o && !div_ready_i) begin
                    div_reg_waddr_i <= div_reg_waddr_o;
                    if (div_divisor_o == 32'd0) begin
                        div_ready_i  <= 1'b1;
                        div_result_i <= rv_div(div_op_o, div_dividend_o, div_divisor_o);
                    end else begin
                        div_busy_i <= 1'b1;
                        m_calc     <= rv_div(div_op_o, div_dividend_o, div_divisor_o);
                        m_cnt      <= 1;
                    end
                end
            end else if (!div_start_o) begin
                div_busy_i   <= 1'b0;
                div_ready_i  <= 1'b1;
                div_result_i <= 64'hDEAD_BEEF_0BAD_F00D;
            end else if (m_cnt == 34) begin
                div_busy_i   <= 1'b0;
                div_ready_i  <= 1'b1;
                div_result_i <= m_calc;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 0;
    localparam int ZSTARTS = 0;
`else
    localparam int ZLAT = 2;
    localparam int ZSTARTS = 1;
`endif

    // Issue one divide, hold req until writeback as the pipeline would,
    // and check latency, start duration, data and the retire cycle.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                         input int exp_lat, input int exp_starts);
        int we_cyc = -1;
        int starts = 0;
        @(posedge clk); #1;
        req_i = 1'b1; op_i = op; reg1_rdata_i = a; reg2_rdata_i = b; reg_waddr_i = rd;
        @(negedge clk);
        check_eq({name, "_hold_req"}, 32'(hold_flag_o), 32'd1);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (cyc == 5 && exp_lat > 5) begin
                check_eq({name, "_dividend_out"}, div_dividend_o, a);
                check_eq({name, "_divisor_out"}, div_divisor_o, b);
            end
            if (reg_we_o) begin
                we_cyc = cyc;
                check_eq({name, "_wdata"}, reg_wdata_o, exp_data);
                check_eq({name, "_waddr"}, 32'(reg_waddr_o), 32'(rd));
                check_eq({name, "_hold_wb"}, 32'(hold_flag_o), 32'd0);
                break;
            end
            if (div_start_o) starts++;
        end
        check_eq({name, "_we_cycle"}, 32'(we_cyc), 32'(exp_lat));
        check_eq({name, "_start_cycles"}, 32'(starts), 32'(exp_starts));
        @(posedge clk); #1;
        req_i = 1'b0;
        @(negedge clk);
        check_eq({name, "_we_after"}, 32'(reg_we_o), 32'd0);
        check_eq({name, "_hold_after"}, 32'(hold_flag_o), 32'd0);
        $display("op %s a=0x%08h b=0x%08h rd=%0d -> wdata=0x%08h we_cycle=%0d starts=%0d",
                 name, a, b, rd, reg_wdata_o, we_cyc, starts);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int starts;
        int hold_low;
        int we_seen;
        int start_seen;

        rst = 1'b1; req_i = 1'b0; op_i = 3'd0; reg1_rdata_i = 32'd0; reg2_rdata_i = 32'd0;
        reg_waddr_i = 5'd0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold", 32'(hold_flag_o), 32'd0);
        check_eq("rst_we", 32'(reg_we_o), 32'd0);
        check_eq("rst_waddr", 32'(reg_waddr_o), 32'd0);
        check_eq("rst_wdata", reg_wdata_o, 32'd0);
        check_eq("rst_start", 32'(div_start_o), 32'd0);
        check_eq("rst_dividend", div_dividend_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Request together with flush must not be accepted
        req_i = 1'b1; op_i = INST_DIVU; reg1_rdata_i = 32'd50; reg2_rdata_i = 32'd5;
        reg_waddr_i = 5'd4; flush_i = 1'b1;
        @(negedge clk);
        check_eq("flushreq_hold", 32'(hold_flag_o), 32'd0);
        @(posedge clk); #1;
        req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check_eq("flushreq_start", 32'(div_start_o), 32'd0);
        check_eq("flushreq_hold_after", 32'(hold_flag_o), 32'd0);
        $display("op flushed_req: not accepted");

        do_op("divu_100_7",  INST_DIVU, 32'd100,        32'd7,          5'd1, 32'd14,         36, 35);
        do_op("rem_m7_2",    INST_REM,  32'hFFFF_FFF9,  32'd2,          5'd2, 32'hFFFF_FFFF,  36, 35);
        do_op("div_m7_2",    INST_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3, 32'hFFFF_FFFD,  36, 35);
        do_op("div_5_0",     INST_DIV,  32'd5,          32'd0,          5'd4, 32'hFFFF_FFFF,  ZLAT, ZSTARTS);
        do_op("remu_5_0",    INST_REMU, 32'd5,          32'd0,          5'd5, 32'd5,          ZLAT, ZSTARTS);
        do_op("div_ovf",     INST_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd6, 32'h8000_0000,  36, 35);
        do_op("rem_ovf",     INST_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7, 32'd0,          36, 35);

        // Flush in cycle 10 of a running DIVU
        @(posedge clk); #1;
        req_i = 1'b1; op_i = INST_DIVU; reg1_rdata_i = 32'd1000; reg2_rdata_i = 32'd3; reg_waddr_i = 5'd9;
        @(negedge clk);
        starts = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (div_start_o) starts++;
        end
        check_eq("flush_starts_before", 32'(starts), 32'd10);
        @(posedge clk); #1;
        flush_i = 1'b1; req_i = 1'b0;
        @(negedge clk);
        check_eq("flush_start_drop", 32'(div_start_o), 32'd0);
        check_eq("flush_hold_c10", 32'(hold_flag_o), 32'd1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        hold_low = -1; we_seen = 0; start_seen = 0;
        for (int cyc = 11; cyc < 40; cyc++) begin
            @(negedge clk);
            if (reg_we_o) we_seen++;
            if (div_start_o) start_seen++;
            if (cyc == 11) check_eq("flush_hold_abort", 32'(hold_flag_o), 32'd1);
            if (!hold_flag_o && hold_low < 0) begin
                hold_low = cyc;
                check_eq("flush_div_idle", 32'(div_busy_i), 32'd0);
            end
        end
        check_eq("flush_hold_release", 32'(hold_low), 32'd13);
        check_eq("flush_no_we", 32'(we_seen), 32'd0);
        check_eq("flush_no_restart", 32'(start_seen), 32'd0);
        $display("op divu_flush: hold released cycle %0d, writebacks %0d", hold_low, we_seen);

        do_op("divu_9_3",    INST_DIVU, 32'd9,          32'd3,          5'd10, 32'd3,         36, 35);
        do_op("remu_7_0",    INST_REMU, 32'd7,          32'd0,          5'd11, 32'd7,         ZLAT, ZSTARTS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
